// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM state type and default dump length.
package regfile_dump_reader_pkg;

  localparam int unsigned DUMP_NREGS = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HALT = 3'd1,
    READ = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } dump_state_e;

endpackage

// File: rtl/dump_out_reg.sv
// Load-enable output holding register with asynchronous active-low clear.
module dump_out_reg #(
  parameter int unsigned W = 38
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug dump engine: stalls the CPU, walks regfile read port 2 and streams {addr, data} words.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = DUMP_NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] dbg_ra,
  input  logic [DATA_W-1:0] dbg_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  localparam int unsigned       OUT_W    = DATA_W + ADDR_W + 1;

  dump_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic              w_load;
  logic [OUT_W-1:0]  w_out_d, w_out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = HALT;
      HALT: if (halt_ack) begin
        w_state_nxt = READ;
        w_idx_nxt   = '0;
      end
      READ: w_state_nxt = SEND;
      SEND: if (out_ready) begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = READ;
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
    // abort wins over everything, including start in IDLE and a pending SEND hold
    if (abort) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end
  end

  assign w_load  = (r_state == READ);
  assign w_out_d = {(r_idx == LAST_IDX), r_idx, dbg_rd};

  dump_out_reg #(
    .W (OUT_W)
  ) u_out_reg (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_load),
    .i_d    (w_out_d),
    .o_q    (w_out_q)
  );

  assign {out_last, out_addr, out_data} = w_out_q;

  assign out_valid = (r_state == SEND);
  assign halt_req  = (r_state == HALT) || (r_state == READ) || (r_state == SEND);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign dbg_ra    = r_idx;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: directed dumps with expected words queued at start.
module tb_regfile_dump_reader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              halt_ack = 1'b0;
  logic              out_ready = 1'b0;
  logic              halt_req, busy, out_valid, out_last, done;
  logic [ADDR_W-1:0] dbg_ra, out_addr;
  logic [DATA_W-1:0] dbg_rd, out_data;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   ndone  = 0;

  regfile_dump_reader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .halt_req  (halt_req),
    .halt_ack  (halt_ack),
    .busy      (busy),
    .dbg_ra    (dbg_ra),
    .dbg_rd    (dbg_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Register file model: R0 reads as zero, Rn = 0x1000_0000 + n
  always_comb dbg_rd = (dbg_ra == '0) ? '0 : 32'h1000_0000 + 32'(dbg_ra);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected word on each accepted transfer and checks hold stability
  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;
  exp_t              e;

  always @(negedge clk) begin
    if (reset) begin
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_addr", 64'(out_addr), 64'(prev_addr));
        chk("hold_data", 64'(out_data), 64'(prev_data));
      end
      if (done) ndone++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got addr %0d expected no word", out_addr);
        end else begin
          e = q.pop_front();
          chk("word_addr", 64'(out_addr), 64'(e.addr));
          chk("word_data", 64'(out_data), 64'(e.data));
          chk("word_last", 64'(out_last), 64'(e.last));
        end
      end
    end
    stall_prev = reset && out_valid && !out_ready && !abort;
    prev_addr  = out_addr;
    prev_data  = out_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    exp_t x;
    for (int n = 0; n < int'(NREGS); n++) begin
      x.addr = ADDR_W'(n);
      x.data = (n == 0) ? 32'h0 : 32'h1000_0000 + 32'(n);
      x.last = (n == int'(NREGS) - 1);
      q.push_back(x);
    end
  endtask

  task automatic wait_done(input logic [31:0] pat);
    for (int c = 0; c < 2000 && !done; c++) begin
      out_ready = pat[c % 32];
      tick();
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic wait_word(input logic [ADDR_W-1:0] a);
    int found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      tick();
      if (out_valid && out_addr == a) found = 1;
    end
    chk("word_reached", 64'(found), 64'd1);
  endtask

  task automatic post_done(input int nd0);
    tick();
    chk("halt_drop", 64'({halt_req, busy}), 64'd0);
    chk("done_once", 64'(ndone - nd0), 64'd1);
    chk("queue_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int nd0;
    int n;
    // reset state
    #2;
    chk("reset_outs", 64'({halt_req, busy, dbg_ra, out_valid, out_addr, out_data, out_last, done}), 64'd0);
    #20 reset = 1'b1;
    tick();

    // T1: halt_ack after 3 cycles, no backpressure
    nd0 = ndone;
    push_dump();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    chk("t1_halt_wait", 64'({halt_req, busy, out_valid}), 64'b110);
    halt_ack = 1'b1;
    wait_done(32'hFFFF_FFFF);
    post_done(nd0);

    // T2: backpressure, ~44% of cycles not ready
    nd0 = ndone;
    push_dump();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(32'hB5A6_9C3B);
    post_done(nd0);

    // T3: halt_ack withheld for 50 cycles
    nd0 = ndone;
    halt_ack = 1'b0;
    push_dump();
    start = 1'b1; tick(); start = 1'b0;
    repeat (50) tick();
    chk("t3_stalled", 64'({busy, halt_req, out_valid, dbg_ra}), 64'({1'b1, 1'b1, 1'b0, 5'd0}));
    halt_ack = 1'b1;
    wait_done(32'hFFFF_FFFF);
    post_done(nd0);

    // T4: abort while word 9 is being offered
    nd0 = ndone;
    push_dump();
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_word(5'd9);
    abort = 1'b1; out_ready = 1'b0;
    tick();
    abort = 1'b0;
    chk("t4_abort", 64'({out_valid, halt_req, busy, dbg_ra}), 64'd0);
    chk("t4_left", 64'(q.size()), 64'd23);
    q.delete();
    repeat (5) tick();
    chk("t4_no_done", 64'(ndone - nd0), 64'd0);
    push_dump();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(32'hFFFF_FFFF);
    post_done(nd0);

    // T5: start+abort in IDLE, then a timed dump with a stray start mid-way
    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_idle_abort", 64'({busy, halt_req}), 64'd0);
    nd0 = ndone;
    push_dump();
    out_ready = 1'b1;
    start = 1'b1;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      n++;
      if (n == 1)  start = 1'b0;
      if (n == 20) start = 1'b1;
      if (n == 21) start = 1'b0;
      if (done) break;
    end
    chk("t5_latency", 64'(n), 64'd66);
    post_done(nd0);
    repeat (3) tick();
    chk("t5_no_restart", 64'(busy), 64'd0);

    // T6: asynchronous reset while word 5 is offered
    push_dump();
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_word(5'd5);
    out_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_async_clr", 64'({halt_req, busy, dbg_ra, out_valid, out_addr, out_data, out_last, done}), 64'd0);
    chk("t6_left", 64'(q.size()), 64'd27);
    q.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("t6_idle", 64'({busy, halt_req, out_valid}), 64'd0);
    nd0 = ndone;
    push_dump();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(32'hFFFF_FFFF);
    post_done(nd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
